ps2_line_assembler: RTL and testbench

- Sits directly upstream of the screen-line tracker.
- Accepts raw PS/2 set-2 scan-code bytes from the keyboard receiver and decodes make/break/extended prefixes.
- Builds an editable 32-character ASCII command line and presents it continuously as a packed 256-bit bus.
- On Enter, emits a one-cycle line-ready strobe with the completed line, then clears for the next command.

---
 rtl/ps2_line_if.sv | 26 ++
 rtl/ps2_line_assembler.sv | 140 ++++++++++++++
 tb/tb_ps2_line_assembler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ps2_line_if.sv
// Bus between the PS/2 keyboard receiver, the line assembler and the
// screen-line tracker. The receiver/bench side drives scan codes (master).
// The assembler drives the line and its status (slave).
interface ps2_line_if;
  logic [7:0]   ps2_key_data;
  logic         ps2_key_pressed;
  logic [255:0] ps2_line_content;
  logic         ps2_line_ready;
  logic [5:0]   cursor_pos;

  modport master (
    output ps2_key_data,
    output ps2_key_pressed,
    input  ps2_line_content,
    input  ps2_line_ready,
    input  cursor_pos
  );

  modport slave (
    input  ps2_key_data,
    input  ps2_key_pressed,
    output ps2_line_content,
    output ps2_line_ready,
    output cursor_pos
  );
endinterface

// File: rtl/ps2_line_assembler.sv
// PS/2 set-2 line assembler: decodes make/break/extended prefixes and builds
// an editable uppercase ASCII command line. Enter commits the line with a
// one-cycle ready strobe, then the line clears.
//
// state   | meaning
// IDLE    | waiting for a make code, prefix or Enter
// BRK     | F0 seen, next byte is a key release and is discarded
// EXT     | E0 seen, next byte is an extended key (unsupported) or F0
// EXT_BRK | E0 F0 seen, next byte is discarded
// COMMIT  | line_ready high for this cycle; line clears on the next edge
module ps2_line_assembler #(
  parameter int         LINE_CHARS = 32,
  parameter logic [7:0] EMPTY_CHAR = 8'h00
) (
  input logic         clock,
  input logic         reset,
  ps2_line_if.slave   bus
);

  localparam int IDX_W = $clog2(LINE_CHARS);

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK,
    COMMIT
  } state_t;

  state_t             state, state_next;
  logic [7:0]         slots [LINE_CHARS];
  logic [5:0]         cursor, cursor_next;
  logic               wr_en, clear;
  logic [IDX_W-1:0]   wr_idx;
  logic [7:0]         wr_char;
  logic [8:0]         map;

  // Scan code to {valid, ascii}; anything not listed is unmapped.
  function automatic logic [8:0] decode(input logic [7:0] code);
    case (code)
      8'h1C: decode = {1'b1, 8'h41}; 8'h32: decode = {1'b1, 8'h42};
      8'h21: decode = {1'b1, 8'h43}; 8'h23: decode = {1'b1, 8'h44};
      8'h24: decode = {1'b1, 8'h45}; 8'h2B: decode = {1'b1, 8'h46};
      8'h34: decode = {1'b1, 8'h47}; 8'h33: decode = {1'b1, 8'h48};
      8'h43: decode = {1'b1, 8'h49}; 8'h3B: decode = {1'b1, 8'h4A};
      8'h42: decode = {1'b1, 8'h4B}; 8'h4B: decode = {1'b1, 8'h4C};
      8'h3A: decode = {1'b1, 8'h4D}; 8'h31: decode = {1'b1, 8'h4E};
      8'h44: decode = {1'b1, 8'h4F}; 8'h4D: decode = {1'b1, 8'h50};
      8'h15: decode = {1'b1, 8'h51}; 8'h2D: decode = {1'b1, 8'h52};
      8'h1B: decode = {1'b1, 8'h53}; 8'h2C: decode = {1'b1, 8'h54};
      8'h3C: decode = {1'b1, 8'h55}; 8'h2A: decode = {1'b1, 8'h56};
      8'h1D: decode = {1'b1, 8'h57}; 8'h22: decode = {1'b1, 8'h58};
      8'h35: decode = {1'b1, 8'h59}; 8'h1A: decode = {1'b1, 8'h5A};
      8'h45: decode = {1'b1, 8'h30}; 8'h16: decode = {1'b1, 8'h31};
      8'h1E: decode = {1'b1, 8'h32}; 8'h26: decode = {1'b1, 8'h33};
      8'h25: decode = {1'b1, 8'h34}; 8'h2E: decode = {1'b1, 8'h35};
      8'h36: decode = {1'b1, 8'h36}; 8'h3D: decode = {1'b1, 8'h37};
      8'h3E: decode = {1'b1, 8'h38}; 8'h46: decode = {1'b1, 8'h39};
      8'h29: decode = {1'b1, 8'h20}; 8'h4E: decode = {1'b1, 8'h2D};
      8'h41: decode = {1'b1, 8'h2C}; 8'h49: decode = {1'b1, 8'h2E};
      default: decode = 9'h000;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and line edit decision for this cycle's byte.
  always_comb begin
    state_next  = state;
    cursor_next = cursor;
    wr_en       = 1'b0;
    wr_idx      = '0;
    wr_char     = EMPTY_CHAR;
    clear       = 1'b0;
    map         = decode(bus.ps2_key_data);
    case (state)
      IDLE: begin
        if (bus.ps2_key_pressed) begin
          if (bus.ps2_key_data == 8'hF0) begin
            state_next = BRK;
          end else if (bus.ps2_key_data == 8'hE0) begin
            state_next = EXT;
          end else if (bus.ps2_key_data == 8'h5A) begin
            state_next = COMMIT;
          end else if (bus.ps2_key_data == 8'h66) begin
            if (cursor != 6'd0) begin
              cursor_next = cursor - 6'd1;
              wr_en       = 1'b1;
              wr_idx      = IDX_W'(cursor - 6'd1);
            end
          end else if (map[8] && (cursor < 6'(LINE_CHARS))) begin
            cursor_next = cursor + 6'd1;
            wr_en       = 1'b1;
            wr_idx      = IDX_W'(cursor);
            wr_char     = map[7:0];
          end
        end
      end
      BRK, EXT_BRK: begin
        if (bus.ps2_key_pressed) state_next = IDLE;
      end
      EXT: begin
        if (bus.ps2_key_pressed)
          state_next = (bus.ps2_key_data == 8'hF0) ? EXT_BRK : IDLE;
      end
      COMMIT: begin
        // Bytes arriving here are dropped; the line is emptied next edge.
        clear      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Character slots and cursor.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int k = 0; k < LINE_CHARS; k++) slots[k] <= EMPTY_CHAR;
      cursor <= 6'd0;
    end else begin
      if (wr_en) slots[wr_idx] <= wr_char;
      cursor <= cursor_next;
    end
  end

  // Pack slots onto the line bus (char 0 in the top byte); the ready pulse
  // is masked by reset so a reset landing in COMMIT cancels it.
  always_comb begin
    bus.ps2_line_content = '0;
    for (int k = 0; k < LINE_CHARS; k++)
      bus.ps2_line_content[(LINE_CHARS-1-k)*8 +: 8] = slots[k];
    bus.ps2_line_ready = (state == COMMIT) && !reset;
    bus.cursor_pos     = cursor;
  end

endmodule

// File: tb/tb_ps2_line_assembler.sv
// Bench for ps2_line_assembler: directed scenarios followed by random scan
// code streams, all compared each cycle against a queue-based line model.
module tb_ps2_line_assembler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  ps2_line_if bus ();

  ps2_line_assembler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: the line as a queue of characters, plus prefix memory.
  logic [7:0] mline[$];
  bit         skip_next;
  bit         after_e0;
  bit         in_commit;

  logic [7:0] codes [40] = '{
    8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
    8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A,
    8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,
    8'h29,8'h4E,8'h41,8'h49};
  string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789 -,.";

  function automatic logic [8:0] lookup(input logic [7:0] d);
    for (int i = 0; i < 40; i++)
      if (codes[i] == d) return {1'b1, chars[i]};
    return 9'h000;
  endfunction

  function automatic logic [255:0] pack_line();
    logic [255:0] v = '0;
    for (int i = 0; i < mline.size(); i++) v[255-8*i -: 8] = mline[i];
    return v;
  endfunction

  task automatic model_update(input bit p, input logic [7:0] d, input bit rst);
    logic [8:0] lk;
    if (rst) begin
      mline.delete(); skip_next = 0; after_e0 = 0; in_commit = 0;
    end else if (in_commit) begin
      mline.delete(); in_commit = 0;
    end else if (p) begin
      if (skip_next) skip_next = 0;
      else if (after_e0) begin
        after_e0 = 0;
        if (d == 8'hF0) skip_next = 1;
      end
      else if (d == 8'hF0) skip_next = 1;
      else if (d == 8'hE0) after_e0 = 1;
      else if (d == 8'h5A) in_commit = 1;
      else if (d == 8'h66) begin
        if (mline.size() > 0) void'(mline.pop_back());
      end else begin
        lk = lookup(d);
        if (lk[8] && mline.size() < 32) mline.push_back(lk[7:0]);
      end
    end
  endtask

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model at the edge, compare just after it.
  task automatic step(input bit p, input logic [7:0] d, input bit rst);
    bus.ps2_key_pressed = p;
    bus.ps2_key_data    = d;
    reset               = rst;
    @(posedge clock);
    model_update(p, d, rst);
    #1;
    check("content", bus.ps2_line_content, pack_line());
    check("cursor", 256'(bus.cursor_pos), 256'(mline.size()));
    check("ready", 256'(bus.ps2_line_ready), 256'(in_commit));
  endtask

  task automatic key(input logic [7:0] d);
    step(1'b1, d, 1'b0);
    step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    bus.ps2_key_pressed = 1'b0;
    bus.ps2_key_data    = 8'h00;

    // Reset then idle.
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);
    check("reset_content", bus.ps2_line_content, 256'h0);
    check("reset_cursor", 256'(bus.cursor_pos), 256'd0);

    // "HI" with release codes interleaved.
    key(8'h33); key(8'hF0); key(8'h33); key(8'h43); key(8'hF0); key(8'h43);
    check("hi_top", 256'(bus.ps2_line_content[255:240]), 256'h4849);
    check("hi_rest", 256'(bus.ps2_line_content[239:0]), 256'h0);
    check("hi_cursor", 256'(bus.cursor_pos), 256'd2);

    // Backspace then an extended make/break pair that must change nothing.
    key(8'h66); key(8'hE0); key(8'h74); key(8'hE0); key(8'hF0); key(8'h74);
    check("bs_top", 256'(bus.ps2_line_content[255:240]), 256'h4800);
    check("bs_cursor", 256'(bus.cursor_pos), 256'd1);

    // Overfill with 34 'A's back to back.
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 34; i++) step(1'b1, 8'h1C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("full_content", bus.ps2_line_content, {32{8'h41}});
    check("full_cursor", 256'(bus.cursor_pos), 256'd32);

    // "GO" then Enter.
    step(1'b0, 8'h00, 1'b1);
    key(8'h34); key(8'h44);
    step(1'b1, 8'h5A, 1'b0);
    check("go_ready", 256'(bus.ps2_line_ready), 256'd1);
    check("go_top", 256'(bus.ps2_line_content[255:240]), 256'h474F);
    step(1'b0, 8'h00, 1'b0);
    check("go_cleared", bus.ps2_line_content, 256'h0);
    check("go_cursor", 256'(bus.cursor_pos), 256'd0);

    // Reset during the commit cycle cancels the pulse.
    key(8'h1C);
    step(1'b1, 8'h5A, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_commit_ready", 256'(bus.ps2_line_ready), 256'd0);
    step(1'b0, 8'h00, 1'b1);
    check("rst_commit_clear", bus.ps2_line_content, 256'h0);

    // Enter on an empty line, then a second Enter dropped during COMMIT.
    step(1'b1, 8'h5A, 1'b0);
    check("empty_ready", 256'(bus.ps2_line_ready), 256'd1);
    check("empty_content", bus.ps2_line_content, 256'h0);
    step(1'b1, 8'h5A, 1'b0);
    check("no_double_ready", 256'(bus.ps2_line_ready), 256'd0);
    step(1'b0, 8'h00, 1'b0);

    // Random streams; Enter is rare in the second half so lines fill up.
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      b = codes[$urandom_range(0, 39)];
      else if (r < 50) b = 8'hF0;
      else if (r < 57) b = 8'hE0;
      else if (r < 66) b = 8'h66;
      else if (r < 72) b = (n < 2000 || r == 66) ? 8'h5A : codes[$urandom_range(0, 39)];
      else             b = 8'($urandom);
      if ($urandom_range(0, 199) == 0) step(1'b0, 8'h00, 1'b1);
      else step($urandom_range(0, 3) != 0, b, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
